// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the multi-channel ADC sequencer.
// Holds the FSM state encoding, the fixed-width result record and the
// oversampling-exponent saturation helper.
package adc_seq_pkg;

   // Widest result fields carried by the result record; narrower
   // instances use the low bits only.
   localparam int RES_DATA_W_MAX = 16;
   localparam int RES_TAG_W_MAX  = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETTLE   = 3'd1,
      ST_PH_UPD   = 3'd2,
      ST_SOC      = 3'd3,
      ST_WAIT_EOC = 3'd4,
      ST_OUT      = 3'd5
   } seq_state_e;

   typedef struct packed {
      logic [RES_DATA_W_MAX-1:0] data;
      logic [RES_TAG_W_MAX-1:0]  ch;
      logic [RES_TAG_W_MAX-1:0]  phase;
      logic                      err;
   } seq_res_t;

   localparam seq_res_t RES_ZERO = '{data: 16'h0000, ch: 8'h00, phase: 8'h00, err: 1'b0};

   // Clamp a requested oversampling exponent to the largest supported one.
   function automatic logic [1:0] osr_sat(input logic [1:0] req, input int unsigned max_log2);
      logic [1:0] v;
      if (int'(req) > int'(max_log2)) begin
         v = 2'(max_log2);
      end else begin
         v = req;
      end
      return v;
   endfunction

endpackage

// File: rtl/adc_seq_chan_pick.sv
// Combinational next-enabled-channel finder.
// With i_from_start set it returns the lowest set bit of i_mask; otherwise
// the lowest set bit strictly above i_cur. o_last is high when no such
// channel exists.
module adc_seq_chan_pick #(
   parameter int NUM_CH = 16,
   parameter int SEL_W  = 4
) (
   input  logic [NUM_CH-1:0] i_mask,
   input  logic [SEL_W-1:0]  i_cur,
   input  logic              i_from_start,
   output logic [SEL_W-1:0]  o_next,
   output logic              o_last
);

   // Scan from the top down so the lowest qualifying channel wins.
   always_comb begin
      o_next = {SEL_W{1'b0}};
      o_last = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         o_next = (i_mask[i] && (i_from_start || (i > int'(i_cur)))) ? SEL_W'(i) : o_next;
         o_last = (i_mask[i] && (i_from_start || (i > int'(i_cur)))) ? 1'b0 : o_last;
      end
   end

endmodule

// File: rtl/adc_sequencer.sv
// Multi-channel ADC sequencer: walks enabled channels and phases, oversamples
// and averages conversions, and streams one tagged result per step.
// Optional feature: define ADC_SEQ_TIMEOUT_EN to abandon a step whose EOC does
// not arrive within TIMEOUT_CYC cycles (result flagged with res_err).
module adc_sequencer
   import adc_seq_pkg::*;
#(
   parameter int NUM_CH       = 16,
   parameter int NUM_PHASE    = 4,
   parameter int DATA_W       = 12,
   parameter int OSR_MAX_LOG2 = 3,
   parameter int SETTLE_W     = 6
`ifdef ADC_SEQ_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC = 255
`endif
) (
   input  logic                          prim_clk,
   input  logic                          prim_rst,
   input  logic                          trig,
   input  logic [NUM_CH-1:0]             ch_en,
   input  logic [1:0]                    osr_log2,
   input  logic [SETTLE_W-1:0]           settle_cyc,
   input  logic                          ms_adc_eoc,
   input  logic [DATA_W-1:0]             ms_adc_data,
   output logic                          ms_adc_soc,
   output logic [$clog2(NUM_CH)-1:0]     ms_afe_sel,
   output logic [NUM_PHASE-1:0]          ms_afe_phase,
   output logic                          ms_afe_phase_update,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [DATA_W-1:0]             res_data,
   output logic [$clog2(NUM_CH)-1:0]     res_ch,
   output logic [$clog2(NUM_PHASE)-1:0]  res_phase,
   output logic                          res_err,
   output logic                          busy,
   output logic                          round_done
);

   localparam int SEL_W = $clog2(NUM_CH);
   localparam int PH_W  = $clog2(NUM_PHASE);
   localparam int ACC_W = DATA_W + OSR_MAX_LOG2;
   localparam int CNT_W = OSR_MAX_LOG2 + 1;

   seq_state_e          r_state;
   seq_state_e          w_state_nxt;
   logic [NUM_CH-1:0]   r_ch_en;
   logic [1:0]          r_osr;
   logic [SETTLE_W-1:0] r_settle;
   logic [SETTLE_W-1:0] r_settle_cnt;
   logic [SEL_W-1:0]    r_sel;
   logic [SEL_W-1:0]    w_sel_nxt;
   logic [PH_W-1:0]     r_ph;
   logic [PH_W-1:0]     w_ph_nxt;
   logic [ACC_W-1:0]    r_acc;
   logic [ACC_W-1:0]    w_acc_sum;
   logic [CNT_W-1:0]    r_smp;
   logic [CNT_W-1:0]    w_smp_inc;
   logic [CNT_W-1:0]    w_smp_tgt;
   seq_res_t            r_res;
   logic                r_soc;
   logic                r_ph_upd;
   logic [NUM_PHASE-1:0] r_phase_oh;
   logic                r_res_valid;
   logic                r_busy;
   logic                r_done;
   logic                w_start;
   logic                w_round_end;
   logic                w_last_ph;
   logic                w_timeout;
   logic [NUM_CH-1:0]   w_pick_mask;
   logic                w_pick_start;
   logic [SEL_W-1:0]    w_pick_next;
   logic                w_pick_last;
   logic                w_res_unused;

   assign w_acc_sum    = r_acc + ACC_W'(ms_adc_data);
   assign w_smp_inc    = r_smp + CNT_W'(1);
   assign w_smp_tgt    = CNT_W'(1) << r_osr;
   assign w_last_ph    = (r_ph == PH_W'(NUM_PHASE - 1));
   assign w_pick_start = (r_state == ST_IDLE);
   assign w_pick_mask  = w_pick_start ? ch_en : r_ch_en;

   adc_seq_chan_pick #(
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W)
   ) u_chan_pick (
      .i_mask       (w_pick_mask),
      .i_cur        (r_sel),
      .i_from_start (w_pick_start),
      .o_next       (w_pick_next),
      .o_last       (w_pick_last)
   );

`ifdef ADC_SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] r_to_cnt;

   // Count consecutive WAIT_EOC cycles without an end-of-conversion.
   always_ff @(posedge prim_clk) begin
      if (prim_rst) begin
         r_to_cnt <= TO_W'(0);
      end else if ((r_state == ST_WAIT_EOC) && !ms_adc_eoc) begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
         r_to_cnt <= TO_W'(0);
      end
   end

   assign w_timeout = (r_state == ST_WAIT_EOC) && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
   assign res_err   = r_res.err;
`else
   assign w_timeout = 1'b0;
   assign res_err   = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge prim_clk) begin
      if (prim_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, next channel/phase selection and round-control decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_ph_nxt    = r_ph;
      w_start     = 1'b0;
      w_round_end = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (trig && (|ch_en)) begin
               w_start     = 1'b1;
               w_sel_nxt   = w_pick_next;
               w_ph_nxt    = PH_W'(0);
               w_state_nxt = (settle_cyc == SETTLE_W'(0)) ? ST_PH_UPD : ST_SETTLE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (r_settle_cnt <= SETTLE_W'(1)) begin
               w_state_nxt = ST_PH_UPD;
            end else begin
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_PH_UPD: begin
            w_state_nxt = ST_SOC;
         end
         ST_SOC: begin
            w_state_nxt = ST_WAIT_EOC;
         end
         ST_WAIT_EOC: begin
            if (ms_adc_eoc) begin
               w_state_nxt = (w_smp_inc < w_smp_tgt) ? ST_SOC : ST_OUT;
            end else if (w_timeout) begin
               w_state_nxt = ST_OUT;
            end else begin
               w_state_nxt = ST_WAIT_EOC;
            end
         end
         ST_OUT: begin
            if (res_ready) begin
               if (!w_last_ph) begin
                  w_ph_nxt    = r_ph + PH_W'(1);
                  w_state_nxt = ST_PH_UPD;
               end else if (!w_pick_last) begin
                  w_sel_nxt   = w_pick_next;
                  w_ph_nxt    = PH_W'(0);
                  w_state_nxt = (r_settle == SETTLE_W'(0)) ? ST_PH_UPD : ST_SETTLE;
               end else begin
                  w_round_end = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_state_nxt = ST_OUT;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath: configuration latch, settle counter, accumulator, result and registered strobes.
   always_ff @(posedge prim_clk) begin
      if (prim_rst) begin
         r_ch_en      <= {NUM_CH{1'b0}};
         r_osr        <= 2'd0;
         r_settle     <= SETTLE_W'(0);
         r_settle_cnt <= SETTLE_W'(0);
         r_sel        <= SEL_W'(0);
         r_ph         <= PH_W'(0);
         r_acc        <= ACC_W'(0);
         r_smp        <= CNT_W'(0);
         r_res        <= RES_ZERO;
         r_soc        <= 1'b0;
         r_ph_upd     <= 1'b0;
         r_phase_oh   <= {NUM_PHASE{1'b0}};
         r_res_valid  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_sel       <= w_sel_nxt;
         r_ph        <= w_ph_nxt;
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_soc       <= (w_state_nxt == ST_SOC);
         r_ph_upd    <= (w_state_nxt == ST_PH_UPD);
         r_res_valid <= (w_state_nxt == ST_OUT);
         r_done      <= w_round_end;
         if (w_state_nxt == ST_PH_UPD) begin
            r_phase_oh <= NUM_PHASE'(1'b1) << w_ph_nxt;
         end
         if (w_start) begin
            r_ch_en  <= ch_en;
            r_osr    <= osr_sat(osr_log2, OSR_MAX_LOG2);
            r_settle <= settle_cyc;
         end
         // Load the settle count on entry, then count down while settling.
         if ((w_state_nxt == ST_SETTLE) && (r_state != ST_SETTLE)) begin
            r_settle_cnt <= w_start ? settle_cyc : r_settle;
         end else if (r_state == ST_SETTLE) begin
            r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
         end
         if (r_state == ST_PH_UPD) begin
            r_acc <= ACC_W'(0);
            r_smp <= CNT_W'(0);
         end else if ((r_state == ST_WAIT_EOC) && ms_adc_eoc) begin
            r_acc <= w_acc_sum;
            r_smp <= w_smp_inc;
         end
         if ((r_state == ST_WAIT_EOC) && (w_state_nxt == ST_OUT)) begin
            if (ms_adc_eoc) begin
               r_res <= '{data:  RES_DATA_W_MAX'(DATA_W'(w_acc_sum >> r_osr)),
                          ch:    RES_TAG_W_MAX'(r_sel),
                          phase: RES_TAG_W_MAX'(r_ph),
                          err:   1'b0};
            end else begin
               r_res <= '{data:  {RES_DATA_W_MAX{1'b0}},
                          ch:    RES_TAG_W_MAX'(r_sel),
                          phase: RES_TAG_W_MAX'(r_ph),
                          err:   1'b1};
            end
         end
      end
   end

   // Pad bits of the fixed-width result record carry no information.
   assign w_res_unused = ^r_res;

   assign ms_adc_soc          = r_soc;
   assign ms_afe_sel          = r_sel;
   assign ms_afe_phase        = r_phase_oh;
   assign ms_afe_phase_update = r_ph_upd;
   assign res_valid           = r_res_valid;
   assign res_data            = r_res.data[DATA_W-1:0];
   assign res_ch              = r_res.ch[SEL_W-1:0];
   assign res_phase           = r_res.phase[PH_W-1:0];
   assign busy                = r_busy;
   assign round_done          = r_done;

endmodule

// File: doc/adc_sequencer.md
# adc_sequencer

Parametrised multi-channel successor to the single-channel conversion controller in the primary clock domain. It walks the analog front-end across an enabled set of channels and a configurable number of phases per channel. It oversamples and averages ADC conversions at each step and delivers one averaged result per (channel, phase) over a valid/ready stream to downstream post-processing. It sits between the ADC/AFE macro pins and the dsp block, and adds a channel mask, programmable settling, oversampling, backpressure and an EOC timeout.

## Interface
- NUM_CH, 16: number of AFE channels; SEL_W = $clog2(NUM_CH)
- NUM_PHASE, 4: phases per channel; ms_afe_phase is one-hot of this width
- DATA_W, 12: ADC data width
- OSR_MAX_LOG2, 3: max oversampling exponent; accumulator width ACC_W = DATA_W+OSR_MAX_LOG2
- SETTLE_W, 6: width of settle-count configuration
- TIMEOUT_CYC, 255: EOC timeout in prim_clk cycles (only with the timeout macro)

Ports:
- prim_clk  in  1  primary clock
- prim_rst  in  1  synchronous active-high reset
- trig  in  1  level; starts a round when sampled high in IDLE
- ch_en  in  NUM_CH  channel enable mask, sampled at round start
- osr_log2  in  2  oversampling exponent, saturated to OSR_MAX_LOG2, sampled at round start
- settle_cyc  in  SETTLE_W  cycles between channel select and first phase update, sampled at round start
- ms_adc_eoc  in  1  ADC end-of-conversion, one-cycle pulse
- ms_adc_data  in  DATA_W  ADC result, valid while ms_adc_eoc is high
- ms_adc_soc  out  1  start-of-conversion pulse
- ms_afe_sel  out  SEL_W  selected channel
- ms_afe_phase  out  NUM_PHASE  one-hot phase
- ms_afe_phase_update  out  1  one-cycle strobe that applies ms_afe_phase
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_data  out  DATA_W  averaged result
- res_ch  out  SEL_W / res_phase  out  $clog2(NUM_PHASE)  tag of the result
- res_err  out  1  result produced by a timeout
- busy  out  1  round in progress
- round_done  out  1  one-cycle pulse after the last result of a round is accepted

## Operation
- FSM states: IDLE, SETTLE, PH_UPD, SOC, WAIT_EOC, OUT.
- IDLE, trig=1 and ch_en≠0: latch configuration, load the lowest enabled channel, go to SETTLE. If ch_en=0, trig is ignored.
- SETTLE: count settle_cyc cycles (0 = skip immediately), then go to PH_UPD.
- PH_UPD: drive ms_afe_phase_update high for one cycle with phase p, clear the accumulator and sample counter, go to SOC.
- SOC: ms_adc_soc high for one cycle, then WAIT_EOC.
- WAIT_EOC, eoc=1: acc += zero-extended ms_adc_data. If samples < 2^osr, go to SOC. Otherwise go to OUT with res_data = acc >> osr (truncating).
- OUT: hold res_* stable until res_valid & res_ready. Then go to the next phase (PH_UPD, no re-settle), or next enabled channel (SETTLE, phase 0), or IDLE with a round_done pulse.
- Disabled channels are skipped with no cycle cost beyond the one transition.
- eoc outside WAIT_EOC is ignored.
- Reset: all outputs 0, ms_afe_phase = 0 (no phase selected), FSM IDLE. Reset mid-round aborts without emitting a result.

## Timing
- trig sampled at edge N: busy=1 and ms_afe_sel valid at N+1.
- First phase update at N+1+settle_cyc. SOC follows one cycle after the phase update.
- eoc sampled at edge M on the final sample: res_valid=1 from M+1.
- Result accepted at edge K: the next PH_UPD or SETTLE starts at K+1; round_done at K+1 on the final result.
- ch_en and osr_log2 changes during a round have no effect until the next round.

## Configuration
- ADC_SEQ_TIMEOUT_EN defined: a counter runs in WAIT_EOC. On reaching TIMEOUT_CYC without eoc, remaining samples for the step are abandoned and OUT is entered with res_data=0, res_err=1. The round continues.
- Macro undefined: the counter is removed, WAIT_EOC waits forever, and res_err is tied to 0.

## Structure
- Package adc_seq_pkg: FSM state enum, sequencer result struct (data/ch/phase/err), osr saturation function.
- Sub-module adc_seq_chan_pick: combinational next-enabled-channel finder (mask, current index → next index, last flag).

## Test plan
- ch_en=16'h0005, osr_log2=0, settle_cyc=3, ADC model returns 100+ch*10+phase → 8 results in order (0,0..3)=100..103, then (2,0..3)=120..123, then round_done.
- osr_log2=2, samples 10,11,12,13 → res_data=11 (46>>2). osr_log2=3 saturates to 8 samples.
- res_ready held low for 20 cycles → res_* stable, no ms_adc_soc issued, sequence resumes the cycle after acceptance.
- ch_en=0 with trig=1 → busy stays 0, no outputs toggle.
- With ADC_SEQ_TIMEOUT_EN and no eoc on ch1 phase2 → after 255 cycles res_err=1, res_data=0, round completes normally.
- prim_rst asserted in WAIT_EOC → next cycle IDLE, soc/valid 0, ms_afe_sel=0; the next trig starts a fresh round from the lowest enabled channel.
